ex_pipe_regs: RTL and testbench
===============================

# ex_pipe_regs

Middle-pipeline register slice of the 5-stage MIPS core. It holds three pieces:
- the combinational immediate extender for the instruction in ID;
- the ID/EX pipeline register, with stall-bubble insertion;
- the EX/MEM pipeline register.

It sits between the decode stage (controller, register-file read, forwarding) and the memory stage (data memory, load extender).

## Interface

Parameters: none.

Ports (`id_*` are ID-stage inputs, `ex_*` are ID/EX register outputs, `ex_alu_rslt` is the EX-stage input, `mem_*` are EX/MEM register outputs):
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-low
- stall  in  2  hazard-unit request; any nonzero value means insert a bubble into ID/EX
- id_instr  in  32  instruction in ID
- id_ext_op  in  2  immediate extension select
- id_imm  out  32  extended immediate, combinational; also the ID/EX imm source
- id_pc4, id_rd1, id_rd2  in  32 each  PC+4 and forwarded register operands
- id_alusrc, id_dmwr, id_rfwr, id_mdiv, id_mr  in  1 each  ALU-B select, mem write, reg write, 64-bit (hi/lo) write, memory read
- id_aluop  in  5
- id_npcop, id_bsel, id_wdsel  in  2 each
- id_msel  in  3
- id_rdst  in  5
- ex_pc4, ex_rd1, ex_rd2, ex_imm  out  32 each  registered copies
- ex_alusrc, ex_aluop, ex_npcop, ex_bsel, ex_msel, ex_dmwr, ex_wdsel, ex_rfwr, ex_rdst, ex_mdiv, ex_mr  out  widths equal to the matching `id_*` port
- ex_alu_rslt  in  64  EX ALU result; [31:0] is the low word / address
- mem_pc4, mem_rd2  out  32 each
- mem_alu_rslt  out  64
- mem_bsel, mem_msel, mem_dmwr, mem_wdsel, mem_rfwr, mem_rdst, mem_mdiv, mem_mr  out  widths equal to the matching `ex_*` port

## Operation

Extender (combinational), with imm16 = id_instr[15:0]:
- 00: zero-extend imm16
- 01: sign-extend imm16 (bit 15 replicated into [31:16])
- 10: {imm16, 16'h0000} (lui)
- 11: zero-extend id_instr[10:6] (shamt)

ID/EX register, at each rising clk:
- rst==0: every ex_* output becomes 0.
- else if stall!=0: bubble; every ex_* output becomes 0. RFWr, DMWr, MDIV and MR are then 0, so nothing downstream commits.
- else: every ex_* output takes its id_* input. ex_imm takes id_imm.

EX/MEM register, at each rising clk:
- rst==0: every mem_* output becomes 0.
- else: unconditional load.
  - mem_pc4 ← ex_pc4
  - mem_alu_rslt ← ex_alu_rslt
  - mem_rd2 ← ex_rd2
  - mem_bsel/msel/dmwr/wdsel/rfwr/rdst/mdiv/mr ← the matching ex_* outputs
- No stall or flush input. A bubble reaches EX/MEM by propagation only.

No arithmetic other than extension. All fields are passed bit-exact with no truncation; the 64-bit ALU result is preserved whole.

## Timing

- id_imm: zero-cycle combinational path from id_instr / id_ext_op.
- ID→EX latency: 1 cycle. ID→MEM latency: 2 cycles.
- Reset is sampled only at rising clk. Asserting it mid-stream clears both registers on that edge; the bubble/zero state then persists until the first edge with rst==1.
- Simultaneous rst==0 and stall!=0: reset wins; the result is identical (all zero).
- Stall lasting N cycles: ID/EX outputs N consecutive bubbles. EX/MEM receives those bubbles one cycle later.
- Outputs change only on the clock edge. No output is combinational from its inputs, except id_imm.

## Test plan

- Extender sweep, id_instr=32'h0000_8005:
  - op 00 → 0000_8005
  - op 01 → FFFF_8005
  - op 10 → 8005_0000
  - op 11 → 0000_0000
- Extender shamt: id_instr=32'h0000_07C0 with op 11 → 0000_001F.
- Reset: hold rst=0 for 2 edges with all inputs nonzero → every ex_* and mem_* is 0. Release rst → the next edge loads.
- Pass-through: id_pc4=0x0000_3004, id_rd1=5, id_rd2=7, id_rfwr=1, id_rdst=9.
  - Edge 1: ex_* match the inputs.
  - Edge 2, with ex_alu_rslt=64'h1_0000_000C: mem_alu_rslt=64'h1_0000_000C, mem_rd2=7, mem_rdst=9, mem_rfwr=1.
- Stall: stall=2'b01 for one cycle with id_rfwr=1, id_dmwr=1.
  - The next edge gives ex_rfwr=ex_dmwr=0 and ex_pc4=0.
  - One cycle later mem_rfwr=0.
  - With stall back at 00, the held ID values load normally.
- Reset mid-stream: a valid instruction is in ID/EX when rst drops for one edge → both registers zero. The instruction in ID at release loads on the following edge.

Source files
------------

// File: rtl/ex_pipe_regs_if.sv
// Signal bundle between the decode stage, the ID/EX and EX/MEM registers
// and the memory stage. The pipeline slice uses the slave side.
interface ex_pipe_regs_if;
    logic [1:0]  stall;
    logic [31:0] id_instr;
    logic [1:0]  id_ext_op;
    logic [31:0] id_imm;
    logic [31:0] id_pc4;
    logic [31:0] id_rd1;
    logic [31:0] id_rd2;
    logic        id_alusrc;
    logic        id_dmwr;
    logic        id_rfwr;
    logic        id_mdiv;
    logic        id_mr;
    logic [4:0]  id_aluop;
    logic [1:0]  id_npcop;
    logic [1:0]  id_bsel;
    logic [1:0]  id_wdsel;
    logic [2:0]  id_msel;
    logic [4:0]  id_rdst;

    logic [31:0] ex_pc4;
    logic [31:0] ex_rd1;
    logic [31:0] ex_rd2;
    logic [31:0] ex_imm;
    logic        ex_alusrc;
    logic [4:0]  ex_aluop;
    logic [1:0]  ex_npcop;
    logic [1:0]  ex_bsel;
    logic [2:0]  ex_msel;
    logic        ex_dmwr;
    logic [1:0]  ex_wdsel;
    logic        ex_rfwr;
    logic [4:0]  ex_rdst;
    logic        ex_mdiv;
    logic        ex_mr;
    logic [63:0] ex_alu_rslt;

    logic [31:0] mem_pc4;
    logic [31:0] mem_rd2;
    logic [63:0] mem_alu_rslt;
    logic [1:0]  mem_bsel;
    logic [2:0]  mem_msel;
    logic        mem_dmwr;
    logic [1:0]  mem_wdsel;
    logic        mem_rfwr;
    logic [4:0]  mem_rdst;
    logic        mem_mdiv;
    logic        mem_mr;

    modport master (
        output stall, id_instr, id_ext_op, id_pc4, id_rd1, id_rd2,
               id_alusrc, id_dmwr, id_rfwr, id_mdiv, id_mr, id_aluop,
               id_npcop, id_bsel, id_wdsel, id_msel, id_rdst, ex_alu_rslt,
        input  id_imm,
               ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_alusrc, ex_aluop, ex_npcop,
               ex_bsel, ex_msel, ex_dmwr, ex_wdsel, ex_rfwr, ex_rdst,
               ex_mdiv, ex_mr,
               mem_pc4, mem_rd2, mem_alu_rslt, mem_bsel, mem_msel, mem_dmwr,
               mem_wdsel, mem_rfwr, mem_rdst, mem_mdiv, mem_mr
    );

    modport slave (
        input  stall, id_instr, id_ext_op, id_pc4, id_rd1, id_rd2,
               id_alusrc, id_dmwr, id_rfwr, id_mdiv, id_mr, id_aluop,
               id_npcop, id_bsel, id_wdsel, id_msel, id_rdst, ex_alu_rslt,
        output id_imm,
               ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_alusrc, ex_aluop, ex_npcop,
               ex_bsel, ex_msel, ex_dmwr, ex_wdsel, ex_rfwr, ex_rdst,
               ex_mdiv, ex_mr,
               mem_pc4, mem_rd2, mem_alu_rslt, mem_bsel, mem_msel, mem_dmwr,
               mem_wdsel, mem_rfwr, mem_rdst, mem_mdiv, mem_mr
    );
endinterface

// File: rtl/ex_pipe_regs.sv
// Middle pipeline slice: ID immediate extender, ID/EX register with bubble
// insertion on stall, and the EX/MEM register. Reset is synchronous, active-low.
module ex_pipe_regs (
    input  logic            clk,
    input  logic            rst,
    ex_pipe_regs_if.slave   bus
);

    logic [31:0] imm_ext;
    logic        instr_unused;

    // Upper opcode/register fields of the instruction are decoded elsewhere.
    assign instr_unused = &{1'b0, bus.id_instr[31:16], bus.id_instr[5:0]};

    // Immediate extender: zero, sign, lui, shamt.
    always_comb begin
        imm_ext = 32'h0000_0000;
        case (bus.id_ext_op)
            2'b00:   imm_ext = {16'h0000, bus.id_instr[15:0]};
            2'b01:   imm_ext = {{16{bus.id_instr[15]}}, bus.id_instr[15:0]};
            2'b10:   imm_ext = {bus.id_instr[15:0], 16'h0000};
            default: imm_ext = {27'd0, bus.id_instr[10:6]};
        endcase
    end

    assign bus.id_imm = imm_ext;

    // ID/EX register: reset and any stall request both load an all-zero bubble.
    always_ff @(posedge clk) begin
        if (!rst || (bus.stall != 2'b00)) begin
            bus.ex_pc4    <= '0;
            bus.ex_rd1    <= '0;
            bus.ex_rd2    <= '0;
            bus.ex_imm    <= '0;
            bus.ex_alusrc <= 1'b0;
            bus.ex_aluop  <= '0;
            bus.ex_npcop  <= '0;
            bus.ex_bsel   <= '0;
            bus.ex_msel   <= '0;
            bus.ex_dmwr   <= 1'b0;
            bus.ex_wdsel  <= '0;
            bus.ex_rfwr   <= 1'b0;
            bus.ex_rdst   <= '0;
            bus.ex_mdiv   <= 1'b0;
            bus.ex_mr     <= 1'b0;
        end else begin
            bus.ex_pc4    <= bus.id_pc4;
            bus.ex_rd1    <= bus.id_rd1;
            bus.ex_rd2    <= bus.id_rd2;
            bus.ex_imm    <= imm_ext;
            bus.ex_alusrc <= bus.id_alusrc;
            bus.ex_aluop  <= bus.id_aluop;
            bus.ex_npcop  <= bus.id_npcop;
            bus.ex_bsel   <= bus.id_bsel;
            bus.ex_msel   <= bus.id_msel;
            bus.ex_dmwr   <= bus.id_dmwr;
            bus.ex_wdsel  <= bus.id_wdsel;
            bus.ex_rfwr   <= bus.id_rfwr;
            bus.ex_rdst   <= bus.id_rdst;
            bus.ex_mdiv   <= bus.id_mdiv;
            bus.ex_mr     <= bus.id_mr;
        end
    end

    // EX/MEM register: loads every cycle; bubbles arrive only by propagation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.mem_pc4      <= '0;
            bus.mem_rd2      <= '0;
            bus.mem_alu_rslt <= '0;
            bus.mem_bsel     <= '0;
            bus.mem_msel     <= '0;
            bus.mem_dmwr     <= 1'b0;
            bus.mem_wdsel    <= '0;
            bus.mem_rfwr     <= 1'b0;
            bus.mem_rdst     <= '0;
            bus.mem_mdiv     <= 1'b0;
            bus.mem_mr       <= 1'b0;
        end else begin
            bus.mem_pc4      <= bus.ex_pc4;
            bus.mem_rd2      <= bus.ex_rd2;
            bus.mem_alu_rslt <= bus.ex_alu_rslt;
            bus.mem_bsel     <= bus.ex_bsel;
            bus.mem_msel     <= bus.ex_msel;
            bus.mem_dmwr     <= bus.ex_dmwr;
            bus.mem_wdsel    <= bus.ex_wdsel;
            bus.mem_rfwr     <= bus.ex_rfwr;
            bus.mem_rdst     <= bus.ex_rdst;
            bus.mem_mdiv     <= bus.ex_mdiv;
            bus.mem_mr       <= bus.ex_mr;
        end
    end

endmodule

// File: tb/tb_ex_pipe_regs.sv
// Bench for ex_pipe_regs: a stage-history model checked every cycle, plus
// directed vectors with hand-computed literal expectations.
module tb_ex_pipe_regs;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic        alusrc;
        logic [4:0]  aluop;
        logic [1:0]  npcop;
        logic [1:0]  bsel;
        logic [2:0]  msel;
        logic        dmwr;
        logic [1:0]  wdsel;
        logic        rfwr;
        logic [4:0]  rdst;
        logic        mdiv;
        logic        mr;
    } stage_t;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] rd2;
        logic [63:0] alu;
        logic [1:0]  bsel;
        logic [2:0]  msel;
        logic        dmwr;
        logic [1:0]  wdsel;
        logic        rfwr;
        logic [4:0]  rdst;
        logic        mdiv;
        logic        mr;
    } mem_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    ex_pipe_regs_if bus();

    ex_pipe_regs u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference extender written straight from the operation table.
    function automatic logic [31:0] ref_ext(input logic [31:0] instr, input logic [1:0] op);
        logic [15:0] h;
        h = instr[15:0];
        if (op == 2'b00) return 32'(h);
        if (op == 2'b01) return h[15] ? (32'hFFFF_0000 | 32'(h)) : 32'(h);
        if (op == 2'b10) return 32'(h) * 32'd65536;
        return 32'((instr >> 6) & 32'h1F);
    endfunction

    stage_t id_now;
    stage_t act_ex;
    mem_t   act_mem;
    stage_t hist_ex;
    mem_t   hist_mem;

    assign id_now = '{pc4: bus.id_pc4, rd1: bus.id_rd1, rd2: bus.id_rd2,
                      imm: ref_ext(bus.id_instr, bus.id_ext_op),
                      alusrc: bus.id_alusrc, aluop: bus.id_aluop, npcop: bus.id_npcop,
                      bsel: bus.id_bsel, msel: bus.id_msel, dmwr: bus.id_dmwr,
                      wdsel: bus.id_wdsel, rfwr: bus.id_rfwr, rdst: bus.id_rdst,
                      mdiv: bus.id_mdiv, mr: bus.id_mr};

    assign act_ex = {bus.ex_pc4, bus.ex_rd1, bus.ex_rd2, bus.ex_imm, bus.ex_alusrc,
                     bus.ex_aluop, bus.ex_npcop, bus.ex_bsel, bus.ex_msel, bus.ex_dmwr,
                     bus.ex_wdsel, bus.ex_rfwr, bus.ex_rdst, bus.ex_mdiv, bus.ex_mr};

    assign act_mem = {bus.mem_pc4, bus.mem_rd2, bus.mem_alu_rslt, bus.mem_bsel,
                      bus.mem_msel, bus.mem_dmwr, bus.mem_wdsel, bus.mem_rfwr,
                      bus.mem_rdst, bus.mem_mdiv, bus.mem_mr};

    // Model: EX holds what ID offered last edge unless reset/stall made it a
    // bubble; MEM holds last cycle's EX contents plus the ALU result.
    always @(posedge clk) begin
        mem_t   nm;
        stage_t ne;
        nm = '0;
        if (rst) begin
            nm = '{pc4: hist_ex.pc4, rd2: hist_ex.rd2, alu: bus.ex_alu_rslt,
                   bsel: hist_ex.bsel, msel: hist_ex.msel, dmwr: hist_ex.dmwr,
                   wdsel: hist_ex.wdsel, rfwr: hist_ex.rfwr, rdst: hist_ex.rdst,
                   mdiv: hist_ex.mdiv, mr: hist_ex.mr};
        end
        ne = (rst && bus.stall == 2'b00) ? id_now : '0;
        hist_ex  = ne;
        hist_mem = nm;
        #1;
        check("ex_stage", 160'(act_ex), 160'(hist_ex));
        check("mem_stage", 160'(act_mem), 160'(hist_mem));
        check("id_imm", 160'(bus.id_imm), 160'(ref_ext(bus.id_instr, bus.id_ext_op)));
    end

    task automatic clear_id();
        bus.id_instr  = '0; bus.id_ext_op = '0; bus.id_pc4 = '0; bus.id_rd1 = '0;
        bus.id_rd2    = '0; bus.id_alusrc = 0;  bus.id_dmwr = 0;  bus.id_rfwr = 0;
        bus.id_mdiv   = 0;  bus.id_mr = 0;      bus.id_aluop = '0; bus.id_npcop = '0;
        bus.id_bsel   = '0; bus.id_wdsel = '0;  bus.id_msel = '0; bus.id_rdst = '0;
    endtask

    task automatic fill_id(input logic [31:0] seed);
        bus.id_instr  = seed ^ 32'h1234_8F3C;
        bus.id_ext_op = seed[1:0];
        bus.id_pc4    = seed + 32'h0000_3000;
        bus.id_rd1    = ~seed;
        bus.id_rd2    = seed * 32'd7;
        bus.id_alusrc = seed[2] | 1'b1;
        bus.id_dmwr   = 1'b1;
        bus.id_rfwr   = 1'b1;
        bus.id_mdiv   = 1'b1;
        bus.id_mr     = 1'b1;
        bus.id_aluop  = seed[8:4] | 5'h1;
        bus.id_npcop  = 2'b11;
        bus.id_bsel   = 2'b10;
        bus.id_wdsel  = 2'b01;
        bus.id_msel   = 3'b101;
        bus.id_rdst   = seed[13:9] | 5'h1;
    endtask

    initial begin
        logic [31:0] r;
        n_vec = 0;
        n_err = 0;
        hist_ex  = '0;
        hist_mem = '0;
        rst = 1'b0;
        bus.stall = 2'b11;
        bus.ex_alu_rslt = 64'hDEAD_BEEF_CAFE_F00D;
        fill_id(32'hA5A5_1111);

        // Reset held two edges with everything nonzero.
        repeat (2) @(negedge clk);
        check("rst_ex_pc4",  160'(bus.ex_pc4), 160'(0));
        check("rst_ex_rfwr", 160'(bus.ex_rfwr), 160'(0));
        check("rst_mem_alu", 160'(bus.mem_alu_rslt), 160'(0));
        check("rst_mem_mr",  160'(bus.mem_mr), 160'(0));

        // Extender sweep (combinational).
        bus.id_instr = 32'h0000_8005;
        bus.id_ext_op = 2'b00; #1 check("ext_zero",  160'(bus.id_imm), 160'(32'h0000_8005));
        bus.id_ext_op = 2'b01; #1 check("ext_sign",  160'(bus.id_imm), 160'(32'hFFFF_8005));
        bus.id_ext_op = 2'b10; #1 check("ext_lui",   160'(bus.id_imm), 160'(32'h8005_0000));
        bus.id_ext_op = 2'b11; #1 check("ext_shamt0", 160'(bus.id_imm), 160'(32'h0000_0000));
        bus.id_instr = 32'h0000_07C0;
        #1 check("ext_shamt", 160'(bus.id_imm), 160'(32'h0000_001F));

        // Pass-through.
        @(negedge clk);
        clear_id();
        bus.id_pc4 = 32'h0000_3004; bus.id_rd1 = 32'd5; bus.id_rd2 = 32'd7;
        bus.id_rfwr = 1'b1; bus.id_rdst = 5'd9;
        bus.stall = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        check("pt_ex_pc4",  160'(bus.ex_pc4), 160'(32'h0000_3004));
        check("pt_ex_rd1",  160'(bus.ex_rd1), 160'(5));
        check("pt_ex_rd2",  160'(bus.ex_rd2), 160'(7));
        check("pt_ex_rfwr", 160'(bus.ex_rfwr), 160'(1));
        check("pt_ex_rdst", 160'(bus.ex_rdst), 160'(9));
        bus.ex_alu_rslt = 64'h1_0000_000C;
        @(negedge clk);
        check("pt_mem_alu",  160'(bus.mem_alu_rslt), 160'(64'h1_0000_000C));
        check("pt_mem_rd2",  160'(bus.mem_rd2), 160'(7));
        check("pt_mem_rdst", 160'(bus.mem_rdst), 160'(9));
        check("pt_mem_rfwr", 160'(bus.mem_rfwr), 160'(1));

        // One-cycle stall.
        bus.id_pc4 = 32'h0000_4000; bus.id_rfwr = 1'b1; bus.id_dmwr = 1'b1;
        bus.stall = 2'b01;
        @(negedge clk);
        check("st_ex_rfwr", 160'(bus.ex_rfwr), 160'(0));
        check("st_ex_dmwr", 160'(bus.ex_dmwr), 160'(0));
        check("st_ex_pc4",  160'(bus.ex_pc4), 160'(0));
        bus.stall = 2'b00;
        @(negedge clk);
        check("st_mem_rfwr", 160'(bus.mem_rfwr), 160'(0));
        check("st_ex_pc4_ld", 160'(bus.ex_pc4), 160'(32'h0000_4000));
        check("st_ex_dmwr_ld", 160'(bus.ex_dmwr), 160'(1));

        // Multi-cycle stalls with the other nonzero codes, then mixed traffic.
        fill_id(32'h0BAD_F00D);
        bus.stall = 2'b10;
        repeat (2) @(negedge clk);
        bus.stall = 2'b11;
        @(negedge clk);
        check("st3_ex_mr", 160'(bus.ex_mr), 160'(0));
        bus.stall = 2'b00;
        for (int i = 0; i < 24; i++) begin
            r = $urandom;
            fill_id(r);
            bus.id_dmwr = r[20];
            bus.id_rfwr = r[21];
            bus.ex_alu_rslt = {r, ~r};
            bus.stall = (r[23:22] == 2'b00) ? 2'(r[25:24]) : 2'b00;
            @(negedge clk);
        end

        // Reset mid-stream.
        bus.stall = 2'b00;
        clear_id();
        bus.id_pc4 = 32'h0000_5000; bus.id_rfwr = 1'b1;
        @(negedge clk);
        bus.id_pc4 = 32'h0000_6000;
        rst = 1'b0;
        bus.stall = 2'b01;
        @(negedge clk);
        check("mr_ex_pc4",  160'(bus.ex_pc4), 160'(0));
        check("mr_ex_rfwr", 160'(bus.ex_rfwr), 160'(0));
        check("mr_mem_pc4", 160'(bus.mem_pc4), 160'(0));
        rst = 1'b1;
        bus.stall = 2'b00;
        @(negedge clk);
        check("mr_ex_pc4_ld",  160'(bus.ex_pc4), 160'(32'h0000_6000));
        check("mr_mem_pc4_0",  160'(bus.mem_pc4), 160'(0));
        @(negedge clk);
        check("mr_mem_pc4_ld", 160'(bus.mem_pc4), 160'(32'h0000_6000));

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
